// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Multiply uses radix-2 Booth. Divide uses restoring division on the operand magnitudes.
// Each takes one iteration per clock. Busy stalls the pipeline while an operation is in flight.
// Optional macro MULTDIV_ZERO_SHORTCUT_EN makes zero operands finish after one iteration.
// Divide-by-zero always takes that one-iteration exit.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMult = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi: Booth accumulator (one guard bit) or division remainder
    logic [WIDTH:0]   hi_q, hi_d;
    // lo: Booth multiplier / product low half, or dividend shifting into quotient
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    // m: multiplicand, or divisor magnitude
    logic [WIDTH-1:0] m_q, m_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic               start;
    logic               cnt_last;
    logic               zero_short;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH-1:0] prod;
    logic               mult_ovf;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign start    = ((state_q == StIdle) || (state_q == StDone)) && (ctrl_MULT || ctrl_DIV);
    assign cnt_last = (cnt_q == CNT_W'(WIDTH));
    assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_ZERO_SHORTCUT_EN
    // At count 0 no iteration has run yet, so m and lo still hold the latched operands.
    assign zero_short = (cnt_q == '0) &&
                        (((state_q == StMult) && ((m_q == '0) || (lo_q == '0))) ||
                         ((state_q == StDiv) && (lo_q == '0)));
`else
    assign zero_short = 1'b0;
`endif

    // Datapath arithmetic for one Booth step and one restoring-division step
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + m_ext;
            2'b10:   booth_sum = hi_q - m_ext;
            default: booth_sum = hi_q;
        endcase
        prod      = {hi_q[WIDTH-1:0], lo_q};
        mult_ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_q};
    end

    // Next-state logic: iteration, completion, and start acceptance
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            StMult: begin
                if (zero_short) begin
                    state_d  = StDone;
                    result_d = '0;
                    exc_d    = 1'b0;
                end else if (cnt_last) begin
                    state_d  = StDone;
                    result_d = prod[WIDTH-1:0];
                    exc_d    = mult_ovf;
                end else begin
                    hi_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
                    qm1_d = lo_q[0];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDiv: begin
                if (m_q == '0) begin
                    state_d  = StDone;
                    result_d = '0;
                    exc_d    = 1'b1;
                end else if (zero_short) begin
                    state_d  = StDone;
                    result_d = '0;
                    exc_d    = 1'b0;
                end else if (cnt_last) begin
                    state_d  = StDone;
                    result_d = neg_q ? -lo_q : lo_q;
                    exc_d    = ovf_q;
                end else begin
                    if (!div_trial[WIDTH]) begin
                        hi_d = div_trial;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase
        // MULT wins when both start inputs are high
        if (start) begin
            cnt_d = '0;
            hi_d  = '0;
            qm1_d = 1'b0;
            if (ctrl_MULT) begin
                state_d = StMult;
                m_d     = data_operandA;
                lo_d    = data_operandB;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                state_d = StDiv;
                m_d     = abs_b;
                lo_d    = abs_a;
                neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                ovf_d   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign busy           = (state_q == StMult) || (state_q == StDiv);
    assign data_resultRDY = (state_q == StDone);
    assign data_result    = result_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed cases plus randomized operations checked
// against an arithmetic reference model on every cycle.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model of the operation in flight
    bit          have_op = 1'b0;
    int          c0 = 0;
    int          lat = 0;
    logic [31:0] exp_res = '0;
    bit          exp_exc = 1'b0;
    logic [31:0] last_res = '0;
    bit          last_exc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Result, exception and latency of one operation from plain signed arithmetic
    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        int     sa;
        int     sb;
        longint p;
        sa = a;
        sb = b;
        if (is_mult) begin
            p       = longint'(sa) * longint'(sb);
            exp_res = p[31:0];
            exp_exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            lat     = 33;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
            if (a == 0 || b == 0) lat = 1;
`endif
        end else if (b == 0) begin
            exp_res = 32'h0;
            exp_exc = 1'b1;
            lat     = 1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            exp_res = 32'h80000000;
            exp_exc = 1'b1;
            lat     = 33;
        end else begin
            exp_res = sa / sb;
            exp_exc = 1'b0;
            lat     = 33;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
            if (a == 0) lat = 1;
`endif
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    bit exp_busy;
    bit exp_rdy;
    always @(negedge clock) begin
        if (!reset) begin
            exp_busy = have_op && (cyc >= c0) && (cyc < c0 + lat);
            exp_rdy  = have_op && (cyc == c0 + lat);
            check("busy", 32'(busy), 32'(exp_busy));
            check("ready", 32'(data_resultRDY), 32'(exp_rdy));
            if (exp_rdy) begin
                last_res = exp_res;
                last_exc = exp_exc;
            end
            check("result", data_result, last_res);
            check("exception", 32'(data_exception), 32'(last_exc));
        end
    end

    // Drive a start for one cycle; now=1 drives within the current cycle
    task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit now);
        if (!now) @(negedge clock);
        #2;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        model(m, a, b);
        c0      = cyc + 1;
        have_op = 1'b1;
        @(negedge clock);
        #2;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Returns at the falling edge inside the expected ready cycle
    task automatic wait_ready();
        int n;
        n = 0;
        while (cyc != c0 + lat) begin
            @(negedge clock);
            n++;
            if (n > 40) begin
                check("ready_timeout", 32'(n), 32'(lat));
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0:       r = 32'h0;
            1:       r = 32'h1;
            2:       r = 32'hFFFFFFFF;
            3:       r = 32'h80000000;
            4:       r = $urandom_range(0, 100);
            5:       r = -$urandom_range(1, 100);
            default: r = $urandom();
        endcase
        return r;
    endfunction

    bit          rm;
    bit          rd;
    bit          rnow;
    logic [31:0] ra;
    logic [31:0] rb;
    int          k;

    initial begin
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(data_resultRDY), 32'h0);
        check("rst_result", data_result, 32'h0);
        check("rst_exception", 32'(data_exception), 32'h0);
        #2 reset = 1'b0;

        start(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0);
        wait_ready();
        check("lit_mul_7x-3", data_result, 32'hFFFFFFEB);
        check("lit_mul_7x-3_exc", 32'(data_exception), 32'h0);

        start(1'b1, 1'b0, 32'h00010000, 32'h00010000, 1'b1);
        wait_ready();
        check("lit_mul_ovf", data_result, 32'h0);
        check("lit_mul_ovf_exc", 32'(data_exception), 32'h1);

        start(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 1'b0);
        wait_ready();
        check("lit_div_-100/7", data_result, 32'hFFFFFFF2);
        check("lit_div_-100/7_exc", 32'(data_exception), 32'h0);

        start(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_ready();
        check("lit_div_min/-1", data_result, 32'h80000000);
        check("lit_div_min/-1_exc", 32'(data_exception), 32'h1);

        start(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
        wait_ready();
        check("lit_div_by_zero", data_result, 32'h0);
        check("lit_div_by_zero_exc", 32'(data_exception), 32'h1);

        // Reset in the middle of a multiply aborts it with no ready pulse
        start(1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
        while (cyc != c0 + 10) @(negedge clock);
        #1;
        reset    = 1'b1;
        have_op  = 1'b0;
        last_res = '0;
        last_exc = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ready", 32'(data_resultRDY), 32'h0);
        check("midrst_result", data_result, 32'h0);
        check("midrst_exception", 32'(data_exception), 32'h0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        start(1'b0, 1'b1, 32'd20, 32'd4, 1'b0);
        wait_ready();
        check("lit_div_20/4", data_result, 32'd5);

        // Both starts high: multiply wins; a start while busy is ignored
        start(1'b1, 1'b1, 32'd6, 32'd3, 1'b0);
        while (cyc != c0 + 4) @(negedge clock);
        #2;
        ctrl_DIV      = 1'b1;
        data_operandB = 32'd0;
        @(negedge clock);
        #2 ctrl_DIV = 1'b0;
        wait_ready();
        check("lit_both_6x3", data_result, 32'd18);
        start(1'b1, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_ready();
        check("lit_done_start", data_result, 32'hFFFFFFFA);

`ifdef MULTDIV_ZERO_SHORTCUT_EN
        start(1'b1, 1'b0, 32'd0, 32'd123, 1'b0);
        wait_ready();
        check("lit_short_lat", 32'(cyc - c0), 32'd1);
        check("lit_short_result", data_result, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra   = pick();
            rb   = pick();
            rm   = 1'($urandom_range(0, 1));
            rd   = !rm || ($urandom_range(0, 3) == 0);
            rnow = ($urandom_range(0, 2) == 0);
            start(rm, rd, ra, rb, rnow);
            if (lat > 10 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 8);
                repeat (k) @(negedge clock);
                #2;
                ctrl_MULT     = 1'($urandom_range(0, 1));
                ctrl_DIV      = 1'b1;
                data_operandA = $urandom();
                data_operandB = $urandom();
                @(negedge clock);
                #2;
                ctrl_MULT = 1'b0;
                ctrl_DIV  = 1'b0;
            end
            wait_ready();
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit. Sits in the execute stage, directly downstream of the D/X control decode.
- Consumes the decoded mult/div start pulses and the operands. Returns a registered result with a ready pulse and an overflow/divide-by-zero exception flag.
- Drives busy so the pipeline holds F/D/X while an operation is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clock  in  1  single clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ctrl_MULT  in  1  start a signed multiply; sampled only when not busy.
- ctrl_DIV  in  1  start a signed divide; sampled only when not busy.
- data_operandA  in  WIDTH  multiplicand or dividend; latched on start.
- data_operandB  in  WIDTH  multiplier or divisor; latched on start.
- data_result  out  WIDTH  low WIDTH bits of the product, or the quotient; registered.
- data_exception  out  1  overflow or divide-by-zero for the last completed operation; registered.
- data_resultRDY  out  1  one-cycle pulse when data_result and data_exception are valid.
- busy  out  1  high while iterating; the pipeline stalls on it.

Behaviour:
- Reset values: state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0. Reset asserted mid-operation aborts the operation; no ready pulse is produced for it.
- States: IDLE, MULT, DIV, DONE. busy = (state is MULT or DIV). data_resultRDY = (state is DONE).
- Start edge E0 is a rising edge with state IDLE or DONE and ctrl_MULT or ctrl_DIV high.
  - At E0: latch operands, clear counter, go to MULT or DIV.
  - If both start inputs are high, MULT wins.
  - Start inputs are ignored while busy.
  - A start accepted in the DONE cycle leaves that cycle's ready pulse intact.
- MULT:
  - Radix-2 Booth algorithm, one iteration per edge on E1..E32. Transition to DONE at E33.
  - Product is a full 64-bit signed value; data_result = product[31:0].
  - data_exception = 1 if product[63:31] is not all-zero and not all-one.
- DIV:
  - Take operand magnitudes; restoring division, one quotient bit per edge on E1..E32. DONE at E33.
  - Quotient is negated when the operand signs differ. Truncation is toward zero; the remainder is discarded.
  - B == 0: go directly to DONE at E1, data_result 0, data_exception 1.
  - A = 0x80000000 with B = 0xFFFFFFFF: data_result 0x80000000, data_exception 1.
- DONE:
  - Lasts one cycle. data_result and data_exception are loaded on the edge entering DONE.
  - Both hold their values until the next entry to DONE.
  - Next state is IDLE, unless a start is accepted.
- Latency: normal operations give data_resultRDY in the cycle after E33; busy is high for the cycles after E0 through E32, 33 cycles in total.

Optional Feature:
- MULTDIV_ZERO_SHORTCUT_EN
- Defined:
  - MULT with A == 0 or B == 0 goes to DONE at E1 with result 0, exception 0.
  - DIV with A == 0 and B != 0 goes to DONE at E1 with result 0, exception 0.
  - busy is high for one cycle in these cases.
- Undefined: zero operands take the full 33-cycle path with identical results. Divide-by-zero always uses the E1 shortcut, whether or not the macro is defined.

Test Plan:
- ctrl_MULT pulse, A=7, B=0xFFFFFFFD (-3) -> busy high 33 cycles, then resultRDY one cycle with data_result 0xFFFFFFEB, exception 0.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> data_result 0x00000000, exception 1, ready after E33.
- ctrl_DIV, A=0xFFFFFF9C (-100), B=7 -> data_result 0xFFFFFFF2 (-14), exception 0. Then A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
- ctrl_DIV, A=5, B=0 -> resultRDY in the cycle after E1, data_result 0, exception 1, busy high one cycle only.
- ctrl_MULT, 9 x 9, with reset asserted mid-cycle after E10 -> all outputs 0 immediately and no ready pulse. After release, ctrl_DIV 20/4 -> result 5 after E33.
- ctrl_MULT and ctrl_DIV both high, A=6, B=3 -> result 18. ctrl_DIV pulsed at E5 is ignored; a start in the DONE cycle is accepted. Shortcut build: MULT 0 x 123 -> ready after E1, result 0.
